// File: rtl/hrm_ctrl_if.sv
// Control bundle between the HRM sequencer and the datapath.
// master = controller (hrm_ctrl); slave = datapath side (PC, IR, RAM, FIFOs).
interface hrm_ctrl_if;
  logic [7:0] IR;
  logic       inbox_empty;
  logic       outbox_full;
  logic       wIR;
  logic       wM;
  logic       wPC;
  logic       branch;
  logic       ijump;
  logic       flagSel;
  logic [1:0] aluCtl;
  logic [1:0] srcR;
  logic       wR;
  logic       mRd;
  logic       mWr;
  logic       inbox_rd;
  logic       outbox_wr;
  logic       halted;
  logic       illegal;

  modport master (
    input  IR, inbox_empty, outbox_full,
    output wIR, wM, wPC, branch, ijump, flagSel, aluCtl, srcR,
           wR, mRd, mWr, inbox_rd, outbox_wr, halted, illegal
  );

  modport slave (
    output IR, inbox_empty, outbox_full,
    input  wIR, wM, wPC, branch, ijump, flagSel, aluCtl, srcR,
           wR, mRd, mWr, inbox_rd, outbox_wr, halted, illegal
  );
endinterface

// File: rtl/hrm_ctrl.sv
// HRM CPU multi-cycle sequencer: fetch/decode/execute state machine driving
// PC, IR/operand loads, data RAM, accumulator, ALU and INBOX/OUTBOX strobes.
module hrm_ctrl (
  input  logic         clk,
  input  logic         rst,
  hrm_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH, LOADIR, DECODE, FETCH_OP, LOADOP, EXEC, WB, INBOX, OUTBOX, HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_INBOX    = 4'h0,
    OP_OUTBOX   = 4'h1,
    OP_COPYFROM = 4'h2,
    OP_COPYTO   = 4'h3,
    OP_ADD      = 4'h4,
    OP_SUB      = 4'h5,
    OP_BUMPUP   = 4'h6,
    OP_BUMPDN   = 4'h7,
    OP_JUMP     = 4'h8,
    OP_JUMPZ    = 4'h9,
    OP_JUMPN    = 4'hA,
    OP_HALT     = 4'hF
  } op_e;

  state_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  op_e    op;
  logic   is_jump;

  assign op      = op_e'(bus.IR[7:4]);
  assign is_jump = (op == OP_JUMP) || (op == OP_JUMPZ) || (op == OP_JUMPN);

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:    state_d = LOADIR;
      LOADIR:   state_d = DECODE;
      DECODE: begin
        case (op)
          OP_INBOX:  state_d = INBOX;
          OP_OUTBOX: state_d = OUTBOX;
          OP_COPYFROM, OP_COPYTO, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN,
          OP_JUMP, OP_JUMPZ, OP_JUMPN:
                     state_d = FETCH_OP;
          OP_HALT: begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          default: begin
            state_d   = HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      FETCH_OP: state_d = LOADOP;
      LOADOP:   state_d = EXEC;
      EXEC: begin
        case (op)
          OP_COPYFROM, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: state_d = WB;
          default:                                           state_d = FETCH;
        endcase
      end
      WB:       state_d = FETCH;
      INBOX:    if (!bus.inbox_empty) state_d = FETCH;
      OUTBOX:   if (!bus.outbox_full) state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // (state forced to FETCH) kills any in-flight write in the same instant.
  always_comb begin
    bus.wIR       = 1'b0;
    bus.wM        = 1'b0;
    bus.wPC       = 1'b0;
    bus.branch    = 1'b0;
    bus.ijump     = 1'b0;
    bus.flagSel   = 1'b0;
    bus.aluCtl    = 2'b00;
    bus.srcR      = 2'b00;
    bus.wR        = 1'b0;
    bus.mRd       = 1'b0;
    bus.mWr       = 1'b0;
    bus.inbox_rd  = 1'b0;
    bus.outbox_wr = 1'b0;
    case (state_q)
      LOADIR: begin
        bus.wIR = 1'b1;
        bus.wPC = 1'b1;
      end
      LOADOP: begin
        bus.wM  = 1'b1;
        bus.wPC = !is_jump;
      end
      EXEC: begin
        case (op)
          OP_COPYTO: bus.mWr = 1'b1;
          OP_COPYFROM, OP_ADD, OP_SUB, OP_BUMPUP, OP_BUMPDN: bus.mRd = 1'b1;
          OP_JUMP: begin
            bus.wPC    = 1'b1;
            bus.branch = 1'b1;
            bus.ijump  = 1'b1;
          end
          OP_JUMPZ: begin
            bus.wPC    = 1'b1;
            bus.branch = 1'b1;
          end
          OP_JUMPN: begin
            bus.wPC     = 1'b1;
            bus.branch  = 1'b1;
            bus.flagSel = 1'b1;
          end
          default: ;
        endcase
      end
      WB: begin
        case (op)
          OP_COPYFROM: begin
            bus.wR   = 1'b1;
            bus.srcR = 2'b01;
          end
          OP_ADD, OP_SUB: begin
            bus.wR     = 1'b1;
            bus.srcR   = 2'b10;
            bus.aluCtl = (op == OP_SUB) ? 2'b01 : 2'b00;
          end
          OP_BUMPUP, OP_BUMPDN: begin
            bus.wR     = 1'b1;
            bus.mWr    = 1'b1;
            bus.srcR   = 2'b10;
            bus.aluCtl = (op == OP_BUMPDN) ? 2'b11 : 2'b10;
          end
          default: ;
        endcase
      end
      INBOX: begin
        bus.inbox_rd = !bus.inbox_empty;
        bus.wR       = !bus.inbox_empty;
      end
      OUTBOX:  bus.outbox_wr = !bus.outbox_full;
      default: ;
    endcase
  end

  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_hrm_ctrl.sv
// Scoreboard bench for hrm_ctrl: a small PC/IR/operand datapath plus ROM,
// directed programs with hand-computed strobe timing per cycle.
module tb_hrm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hrm_ctrl_if bus ();
  hrm_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] rom [256];
  logic [7:0] pc_q, ir_q, opr_q;
  logic       flag_z, flag_n, in_empty, out_full, alu_flag;
  logic [14:0] vec;

  assign bus.IR          = ir_q;
  assign bus.inbox_empty = in_empty;
  assign bus.outbox_full = out_full;
  assign alu_flag        = bus.flagSel ? flag_n : flag_z;
  assign vec = {bus.wIR, bus.wM, bus.wPC, bus.branch, bus.ijump, bus.flagSel,
                bus.aluCtl, bus.srcR, bus.wR, bus.mRd, bus.mWr,
                bus.inbox_rd, bus.outbox_wr};

  localparam logic [14:0] WIR = 15'h4000, WM = 15'h2000, WPC = 15'h1000,
                          BR = 15'h0800, IJ = 15'h0400, FS = 15'h0200,
                          ALU_ADD = 15'h0000, ALU_SUB = 15'h0080,
                          ALU_INC = 15'h0100, ALU_DEC = 15'h0180,
                          SRC_IN = 15'h0000, SRC_RAM = 15'h0020, SRC_ALU = 15'h0040,
                          WR = 15'h0010, MRD = 15'h0008, MWR = 15'h0004,
                          IRD = 15'h0002, OWR = 15'h0001;
  localparam logic [14:0] LD = WIR | WPC;
  localparam logic [14:0] OP = WM | WPC;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= 8'h00;
      ir_q  <= 8'h00;
      opr_q <= 8'h00;
    end else begin
      if (bus.wIR) ir_q  <= rom[pc_q];
      if (bus.wM)  opr_q <= rom[pc_q];
      if (bus.wPC) pc_q  <= (bus.branch && (bus.ijump || alu_flag)) ? opr_q : pc_q + 8'd1;
    end
  end

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 1;
    else      cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic [14:0] v; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_at(input int cy, input logic [14:0] vv);
    q.push_back('{cyc: cy, v: vv});
  endtask

  always @(negedge clk) begin
    if (rst && vec != 15'h0) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: cycle %0d got 0x%0h expected none", cyc, vec);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("strobe_vec", 32'(vec), 32'(mon_e.v));
      end
    end
  end

  task automatic fill_rom();
    for (int unsigned i = 0; i < 256; i++) rom[i] = 8'hF0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({vec, bus.halted, bus.illegal}), 32'h0);
    chk("reset_pc", 32'(pc_q), 32'h0);
    #2 rst = 1'b1;
  endtask

  task automatic at_cycle(input int n);
    int k = 0;
    while (cyc < n && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL timeout_cycle: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic drain(input string name);
    chk(name, 32'(q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_empty = 1'b0; out_full = 1'b0; flag_z = 1'b0; flag_n = 1'b0;

    // INBOX with three stalled cycles, then HALT
    fill_rom(); rom[0] = 8'h00;
    in_empty = 1'b1;
    apply_reset();
    expect_at(2, LD); expect_at(7, IRD | WR | SRC_IN); expect_at(9, LD);
    at_cycle(7); in_empty = 1'b0;
    at_cycle(12);
    chk("inbox_halted", 32'({bus.halted, bus.illegal}), 32'h2);
    chk("inbox_pc", 32'(pc_q), 32'h02);
    drain("inbox_queue");

    // JUMPZ taken
    fill_rom(); rom[0] = 8'h90; rom[1] = 8'h20;
    flag_z = 1'b1; flag_n = 1'b0;
    apply_reset();
    expect_at(2, LD); expect_at(5, WM); expect_at(6, WPC | BR); expect_at(8, LD);
    at_cycle(7); chk("jumpz_taken_pc", 32'(pc_q), 32'h20);
    at_cycle(10); drain("jumpz_taken_queue");

    // JUMPZ not taken (negative flag set to expose a wrong flagSel)
    flag_z = 1'b0; flag_n = 1'b1;
    apply_reset();
    expect_at(2, LD); expect_at(5, WM); expect_at(6, WPC | BR); expect_at(8, LD);
    at_cycle(7); chk("jumpz_untaken_pc", 32'(pc_q), 32'h02);
    at_cycle(10); drain("jumpz_untaken_queue");

    // JUMPN taken
    fill_rom(); rom[0] = 8'hA0; rom[1] = 8'h30;
    flag_z = 1'b0; flag_n = 1'b1;
    apply_reset();
    expect_at(2, LD); expect_at(5, WM); expect_at(6, WPC | BR | FS); expect_at(8, LD);
    at_cycle(7); chk("jumpn_pc", 32'(pc_q), 32'h30);
    at_cycle(10); drain("jumpn_queue");

    // BUMP+ 0x05
    fill_rom(); rom[0] = 8'h60; rom[1] = 8'h05;
    flag_z = 1'b0; flag_n = 1'b0;
    apply_reset();
    expect_at(2, LD); expect_at(5, OP); expect_at(6, MRD);
    expect_at(7, WR | MWR | SRC_ALU | ALU_INC); expect_at(9, LD);
    at_cycle(6); chk("bump_operand", 32'(opr_q), 32'h05);
    at_cycle(8); chk("bump_pc", 32'(pc_q), 32'h02);
    at_cycle(12); drain("bump_queue");

    // Mixed program: COPYFROM, COPYTO, ADD, SUB, BUMP-, JUMP, OUTBOX (stalled), HALT
    fill_rom();
    rom[0] = 8'h20; rom[1] = 8'h03; rom[2] = 8'h30; rom[3] = 8'h04;
    rom[4] = 8'h40; rom[5] = 8'h07; rom[6] = 8'h50; rom[7] = 8'h05;
    rom[8] = 8'h70; rom[9] = 8'h06; rom[10] = 8'h80; rom[11] = 8'h0E;
    rom[14] = 8'h10;
    out_full = 1'b1;
    apply_reset();
    expect_at(2, LD);  expect_at(5, OP);  expect_at(6, MRD);  expect_at(7, WR | SRC_RAM);
    expect_at(9, LD);  expect_at(12, OP); expect_at(13, MWR);
    expect_at(15, LD); expect_at(18, OP); expect_at(19, MRD); expect_at(20, WR | SRC_ALU | ALU_ADD);
    expect_at(22, LD); expect_at(25, OP); expect_at(26, MRD); expect_at(27, WR | SRC_ALU | ALU_SUB);
    expect_at(29, LD); expect_at(32, OP); expect_at(33, MRD); expect_at(34, WR | MWR | SRC_ALU | ALU_DEC);
    expect_at(36, LD); expect_at(39, WM); expect_at(40, WPC | BR | IJ);
    expect_at(42, LD); expect_at(46, OWR); expect_at(48, LD);
    at_cycle(41); chk("jump_pc", 32'(pc_q), 32'h0E);
    // Flag drops and returns between edges: must not be seen
    at_cycle(45); out_full = 1'b0; #2 out_full = 1'b1;
    at_cycle(46); out_full = 1'b0;
    at_cycle(52);
    chk("mixed_pc", 32'(pc_q), 32'h10);
    chk("mixed_halted", 32'({bus.halted, bus.illegal}), 32'h2);
    drain("mixed_queue");

    // Illegal opcode, then async reset clears the sticky flags
    fill_rom(); rom[0] = 8'hC0;
    apply_reset();
    expect_at(2, LD);
    at_cycle(6);
    chk("illegal_flags", 32'({bus.halted, bus.illegal}), 32'h3);
    chk("illegal_pc", 32'(pc_q), 32'h01);
    drain("illegal_queue");
    rst = 1'b0; #1;
    chk("reset_clears_flags", 32'({bus.halted, bus.illegal}), 32'h0);

    // Reset asserted during ADD write-back
    fill_rom(); rom[0] = 8'h40; rom[1] = 8'h07;
    apply_reset();
    expect_at(2, LD); expect_at(5, OP); expect_at(6, MRD);
    at_cycle(7);
    chk("wb_wr_before_reset", 32'(bus.wR), 32'h1);
    rst = 1'b0; #1;
    chk("wb_strobes_after_reset", 32'(vec), 32'h0);
    drain("midreset_queue");
    apply_reset();
    chk("midreset_halted", 32'(bus.halted), 32'h0);
    expect_at(2, LD); expect_at(5, OP); expect_at(6, MRD);
    expect_at(7, WR | SRC_ALU | ALU_ADD); expect_at(9, LD);
    at_cycle(12);
    chk("midreset_rerun_pc", 32'(pc_q), 32'h03);
    drain("midreset_rerun_queue");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hrm_ctrl.md
# hrm_ctrl

Multi-cycle control unit for the HRM CPU. It sequences instruction fetch, decode and execute by driving the PC controls (wPC, branch, ijump), the instruction and operand registers, the data RAM, the accumulator write path, the ALU function and the INBOX/OUTBOX handshakes. It sits between the program ROM/IR and the datapath, and is the only block that writes PC.

## Interface
- No parameters. Opcode map is fixed (see Operation).
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. Only this signal resets the block.
- `IR` in 8: current instruction register contents. Opcode is IR[7:4].
- `inbox_empty` in 1: INBOX FIFO has no data.
- `outbox_full` in 1: OUTBOX FIFO cannot accept data.
- `wIR` out 1: load the ROM data into IR.
- `wM` out 1: load the ROM data into the operand register, which serves as both the RAM address and `jmpAddr`.
- `wPC`, `branch`, `ijump` out 1 each: PC controls. The PC computes `PC <= (branch && (ijump || aluFlag)) ? jmpAddr : PC+1` when wPC is high.
- `flagSel` out 1: selects `aluFlag`. 0 = zero flag, 1 = negative flag.
- `aluCtl` out 2: 00 add, 01 sub, 10 inc, 11 dec. The operands are accumulator R and RAM data.
- `srcR` out 2: accumulator source. 00 inbox, 01 RAM data, 10 ALU.
- `wR` out 1: write the accumulator.
- `mRd`, `mWr` out 1 each: data RAM read/write. Reads are synchronous, with data valid the next cycle. Writes take R, or the ALU result for BUMP.
- `inbox_rd`, `outbox_wr` out 1 each: FIFO pop/push strobes.
- `halted`, `illegal` out 1 each: sticky status flags.

## Operation
- Opcodes:
  - 0 INBOX, 1 OUTBOX: 1-byte instructions.
  - 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMP+, 7 BUMP-, 8 JUMP, 9 JUMPZ, A JUMPN: 2-byte instructions (opcode byte, then operand byte).
  - F HALT.
  - B–E are illegal.
- States: FETCH, LOADIR, DECODE, FETCH_OP, LOADOP, EXEC, WB, INBOX, OUTBOX, HALT.
- FETCH: the ROM is presented with PC. No strobes. Go to LOADIR.
- LOADIR: wIR=1, wPC=1 (PC+1). Go to DECODE.
- DECODE:
  - Op 0 → INBOX. Op 1 → OUTBOX.
  - Ops 2–A → FETCH_OP.
  - Op F → HALT with halted=1.
  - Ops B–E → HALT with halted=1 and illegal=1.
- FETCH_OP: ROM wait. Go to LOADOP.
- LOADOP: wM=1. wPC=1 except for ops 8–A (a jump leaves PC on the operand byte). Go to EXEC.
- EXEC:
  - COPYTO: mWr=1, then FETCH.
  - COPYFROM/ADD/SUB/BUMP±: mRd=1, then WB.
  - JUMP: wPC=1, branch=1, ijump=1.
  - JUMPZ: wPC=1, branch=1, flagSel=0.
  - JUMPN: same as JUMPZ with flagSel=1.
  - All jumps go to FETCH afterwards. An untaken jump increments PC past the operand byte.
- WB (all cases go to FETCH):
  - COPYFROM: wR=1, srcR=01.
  - ADD/SUB: wR=1, srcR=10, aluCtl=00/01.
  - BUMP±: wR=1, mWr=1, srcR=10, aluCtl=10/11.
- INBOX: while inbox_empty, hold with no strobes. When it is clear, inbox_rd=1, wR=1, srcR=00 in the same cycle, then FETCH.
- OUTBOX: while outbox_full, hold. When it is clear, outbox_wr=1, then FETCH.
- HALT: absorbing state. All strobes are 0. Only reset exits it.
- Strobe decoding:
  - Strobes are combinational from the state register and IR.
  - inbox_rd, wR in INBOX and outbox_wr additionally depend on the FIFO flags.
  - At most one wPC pulse is issued per state.
  - wIR and wM are never asserted together.

## Timing
- Reset (rst=0, asynchronous): state=FETCH, halted=0, illegal=0, every strobe 0 immediately. The PC is reset to 0 by the same system reset.
- The first FETCH occurs on the first rising edge after rst deasserts.
- Cycles per instruction (no stalls):
  - INBOX/OUTBOX: 4.
  - COPYTO, JUMP/JUMPZ/JUMPN: 6.
  - COPYFROM, ADD, SUB, BUMP±: 7.
  - HALT/illegal: 3 to reach HALT.
- Each FIFO stall adds exactly one cycle per cycle the flag is held. A strobe fires on the first edge where the flag is clear.
- A flag that clears and reasserts in the same cycle has no effect: the FIFO flags are sampled only at the clock edge.
- PC wrap: PC is 8 bits, so 0xFF+1 = 0x00. The controller is unaware of the wrap.
- If rst is asserted mid-instruction (including EXEC/WB), no partial write completes after assertion, and the next instruction starts from FETCH at PC=0.

## Test plan
- Reset: hold rst=0 for 3 cycles → all outputs 0. After release, the strobe sequence is wIR+wPC in cycle 2 and FETCH resumes at PC=0.
- INBOX stall: program {0x00}, inbox_empty=1 for 3 cycles, then 0 → inbox_rd and wR high for exactly 1 cycle, in cycle 7 after reset release, with srcR=00.
- JUMPZ: program {0x90, 0x20} (JUMPZ 0x20) at PC=0.
  - aluFlag=1 → PC=0x20 after 6 cycles.
  - aluFlag=0 → PC=0x02.
  - flagSel=0 during EXEC.
- BUMP+: program {0x60, 0x05} → mRd asserted in EXEC, with wM having loaded 0x05. WB has wR=1, mWr=1, aluCtl=10, srcR=10. Total 7 cycles.
- HALT/illegal:
  - Opcode 0xF0 → halted=1, illegal=0, and no further wPC ever.
  - Opcode 0xC0 → halted=1, illegal=1.
- Reset mid-ADD: assert rst during WB → wR drops immediately. After release, FETCH occurs at PC=0 and halted=0.
